// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and a
// constant-foldable log2 used to size shift amounts and layer counts.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Per-stage side fields travelling with the data word.
  typedef struct packed {
    op_e  op;
    logic sign;
  } shift_meta_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational barrel-shifter layer: shifts by 2^K when en_i is set,
// otherwise passes data through unchanged.
module shift_layer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  op_e              op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;

  // SRA fills from the operand's original MSB, not this layer's input MSB.
  always_comb begin
    shifted = data_i;
    case (op_i)
      OP_SLL:  shifted = {data_i[WIDTH-S-1:0], {S{1'b0}}};
      OP_SRL:  shifted = {{S{1'b0}}, data_i[WIDTH-1:S]};
      OP_SRA:  shifted = {{S{sign_i}}, data_i[WIDTH-1:S]};
      default: shifted = {data_i[S-1:0], data_i[WIDTH-1:S]};
    endcase
    data_o = en_i ? shifted : data_i;
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides; REG_MASK picks
// which layers are followed by a register stage.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int                      WIDTH     = 32,
  parameter logic [clog2(WIDTH)-1:0] REG_MASK  = 5'b10100,
  parameter bit                      ZERO_FLAG = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero
);

  localparam int SW = clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    shamt;
    shift_meta_t      meta;
  } pl_t;

  pl_t pl_src;
  pl_t pl_out;

  always_comb begin
    pl_src           = '0;
    pl_src.data      = in_data;
    pl_src.shamt     = in_shamt;
    pl_src.meta.op   = op_e'(in_op);
    pl_src.meta.sign = in_data[WIDTH-1];
  end

  for (genvar k = 0; k < SW; k++) begin : g_layer
    pl_t              pl_in, pl_d, pl_o;
    logic             vld_in, vld_o, rdy_in, rdy_o;
    logic [WIDTH-1:0] data_d;

    if (k == 0) begin : g_first
      assign pl_in  = pl_src;
      assign vld_in = in_valid;
    end else begin : g_mid
      assign pl_in  = g_layer[k-1].pl_o;
      assign vld_in = g_layer[k-1].vld_o;
    end

    if (k == SW - 1) begin : g_tail
      assign rdy_o = out_ready;
    end else begin : g_next
      assign rdy_o = g_layer[k+1].rdy_in;
    end

    shift_layer #(.WIDTH(WIDTH), .K(k)) u_layer (
      .data_i (pl_in.data),
      .en_i   (pl_in.shamt[k]),
      .op_i   (pl_in.meta.op),
      .sign_i (pl_in.meta.sign),
      .data_o (data_d)
    );

    always_comb begin
      pl_d      = pl_in;
      pl_d.data = data_d;
    end

    if (REG_MASK[k]) begin : g_reg
      pl_t  pl_q;
      logic vld_q;

      // Empty stages always load, so bubbles collapse under a stall.
      assign rdy_in = !vld_q || rdy_o;

      always_ff @(posedge clock) begin
        if (reset) begin
          pl_q  <= '0;
          vld_q <= 1'b0;
        end else if (rdy_in) begin
          pl_q  <= pl_d;
          vld_q <= vld_in;
        end
      end

      assign pl_o  = pl_q;
      assign vld_o = vld_q;
    end else begin : g_wire
      assign rdy_in = rdy_o;
      assign pl_o   = pl_d;
      assign vld_o  = vld_in;
    end
  end

  assign pl_out    = g_layer[SW-1].pl_o;
  assign out_valid = g_layer[SW-1].vld_o;
  assign out_data  = pl_out.data;
  assign in_ready  = g_layer[0].rdy_in;

  logic unused_tail;
  assign unused_tail = ^{pl_out.shamt, pl_out.meta};

  if (ZERO_FLAG) begin : g_zero
    assign out_zero = out_valid && (pl_out.data == '0);
  end else begin : g_nozero
    assign out_zero = 1'b0;
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit two-stage pipe plus a combinational
// 8-bit instance and a fully registered 64-bit instance.
module tb_shift_pipe;
  import shift_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;

  logic        s8_iv, s8_ir, s8_ov, s8_ordy, s8_oz;
  logic [7:0]  s8_id, s8_od;
  logic [2:0]  s8_sh;
  logic [1:0]  s8_op;

  logic        s64_iv, s64_ir, s64_ov, s64_ordy, s64_oz;
  logic [63:0] s64_id, s64_od;
  logic [5:0]  s64_sh;
  logic [1:0]  s64_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  shift_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  shift_pipe #(.WIDTH(8), .REG_MASK(3'b000), .ZERO_FLAG(1'b1)) dut8 (
    .clock(clock), .reset(reset), .in_valid(s8_iv), .in_ready(s8_ir),
    .in_data(s8_id), .in_shamt(s8_sh), .in_op(s8_op), .out_valid(s8_ov),
    .out_ready(s8_ordy), .out_data(s8_od), .out_zero(s8_oz)
  );

  shift_pipe #(.WIDTH(64), .REG_MASK(6'b111111), .ZERO_FLAG(1'b1)) dut64 (
    .clock(clock), .reset(reset), .in_valid(s64_iv), .in_ready(s64_ir),
    .in_data(s64_id), .in_shamt(s64_sh), .in_op(s64_op), .out_valid(s64_ov),
    .out_ready(s64_ordy), .out_data(s64_od), .out_zero(s64_oz)
  );

  // Bit-by-bit reference, independent of the layered structure.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w,
                                            input int sh, input logic [1:0] op);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'b00:   r[i] = (i >= sh) ? d[(i - sh) & 63] : 1'b0;
        2'b01:   r[i] = (i + sh < w) ? d[(i + sh) & 63] : 1'b0;
        2'b10:   r[i] = (i + sh < w) ? d[(i + sh) & 63] : d[w-1];
        default: r[i] = d[(i + sh) % w];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the 32-bit pipe empty.
  task automatic send_chk(input string tag, input logic [31:0] d, input int sh,
                          input logic [1:0] op, input logic [31:0] exp);
    int cyc;
    in_valid = 1'b1; in_data = d; in_shamt = sh[4:0]; in_op = op; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(2));
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    chk({tag, "_zero"}, 64'(out_zero), 64'(exp == 32'd0));
    @(negedge clock);
  endtask

  task automatic send64(input string tag, input logic [63:0] d, input int sh,
                        input logic [1:0] op);
    logic [63:0] exp;
    int cyc;
    exp = ref_shift(d, 64, sh, op);
    s64_iv = 1'b1; s64_id = d; s64_sh = sh[5:0]; s64_op = op; s64_ordy = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(s64_ir), 64'(1));
    @(negedge clock);
    s64_iv = 1'b0;
    cyc = 1;
    while (!s64_ov && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(6));
    chk({tag, "_data"}, s64_od, exp);
    chk({tag, "_zero"}, 64'(s64_oz), 64'(exp == 64'd0));
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nsent, nrecv;
    logic [63:0] exp;
    int sh;
    logic [1:0] op;

    reset = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd3; in_op = 2'b00; out_ready = 1'b1;
    s8_iv = 1'b0; s8_id = '0; s8_sh = '0; s8_op = '0; s8_ordy = 1'b1;
    s64_iv = 1'b0; s64_id = '0; s64_sh = '0; s64_op = '0; s64_ordy = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_zero", 64'(out_zero), 64'(0));
    chk("rst64_out_valid", 64'(s64_ov), 64'(0));
    reset = 1'b0; in_valid = 1'b0;
    #1 chk("rst_in_ready", 64'(in_ready), 64'(1));

    send_chk("sra31", 32'h8000_0000, 31, OP_SRA, 32'hFFFF_FFFF);
    send_chk("sra4", 32'h7000_0000, 4, OP_SRA, 32'h0700_0000);
    send_chk("sll1", 32'h8000_0001, 1, OP_SLL, 32'h0000_0002);
    send_chk("srl1", 32'h8000_0001, 1, OP_SRL, 32'h4000_0000);
    send_chk("sra1", 32'h8000_0001, 1, OP_SRA, 32'hC000_0000);
    send_chk("ror1", 32'h8000_0001, 1, OP_ROR, 32'hC000_0000);
    send_chk("sll0", 32'h8000_0001, 0, OP_SLL, 32'h8000_0001);
    send_chk("srl0", 32'h8000_0001, 0, OP_SRL, 32'h8000_0001);
    send_chk("sra0", 32'h8000_0001, 0, OP_SRA, 32'h8000_0001);
    send_chk("ror0", 32'h8000_0001, 0, OP_ROR, 32'h8000_0001);
    send_chk("sll_zero", 32'h8000_0000, 1, OP_SLL, 32'h0000_0000);

    // Back-to-back streaming with the consumer always ready.
    out_ready = 1'b1;
    for (int n = 0; n < 11; n++) begin
      in_valid = (n < 8); in_data = 32'hF000_0000; in_shamt = n[4:0]; in_op = OP_SRL;
      #1;
      if (n < 8) chk("b2b_in_ready", 64'(in_ready), 64'(1));
      if (n >= 2) begin
        chk("b2b_out_valid", 64'(out_valid), 64'(n < 10));
        if (n < 10) chk("b2b_data", 64'(out_data), 64'(32'hF000_0000 >> (n - 2)));
      end
      @(negedge clock);
    end
    in_valid = 1'b0;

    // Backpressure: consumer stalls 5 cycles, then releases.
    nsent = 0; nrecv = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 5);
      in_valid = (nsent < 6); in_data = 32'hA0 + nsent; in_shamt = 5'd0; in_op = OP_SLL;
      #1;
      if (c >= 2 && c < 5) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_data", 64'(out_data), 64'(32'hA0));
      end
      if (c == 5) chk("bp_release_ready", 64'(in_ready), 64'(1));
      if (out_valid && out_ready) begin
        chk("bp_order", 64'(out_data), 64'(32'hA0 + nrecv));
        nrecv++;
      end
      if (in_valid && in_ready) nsent++;
      if (c == 4) chk("bp_accepts_in_stall", 64'(nsent), 64'(2));
      @(negedge clock);
      if (nrecv == 6) break;
    end
    chk("bp_received", 64'(nrecv), 64'(6));
    in_valid = 1'b0;
    #1 chk("bp_drained", 64'(out_valid), 64'(0));
    @(negedge clock);

    // Reset with two entries in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_op = OP_SLL; in_shamt = 5'd0; in_data = 32'h111;
    @(negedge clock);
    in_data = 32'h222;
    @(negedge clock);
    #1 chk("pre_rst_full", 64'(out_valid), 64'(1));
    reset = 1'b1; in_data = 32'h333;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1 chk("rst_flush_valid", 64'(out_valid), 64'(0));
    send_chk("post_rst", 32'h0000_0F0F, 4, OP_SLL, 32'h0000_F0F0);

    // 8-bit combinational instance.
    s8_ordy = 1'b0; s8_iv = 1'b1;
    #1 chk("w8_ready_follows", 64'(s8_ir), 64'(0));
    s8_ordy = 1'b1; s8_id = 8'h01; s8_sh = 3'd7; s8_op = OP_SLL;
    #1 chk("w8_sll_max", 64'(s8_od), 64'(8'h80));
    chk("w8_sll_max_zero", 64'(s8_oz), 64'(0));
    s8_sh = 3'd1; s8_op = OP_SRL;
    #1 chk("w8_srl_zero", 64'(s8_oz), 64'(1));
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      s8_id = 8'($urandom); sh = $urandom_range(0, 7); op = 2'($urandom_range(0, 3));
      s8_sh = sh[2:0]; s8_op = op;
      #1;
      exp = ref_shift({56'd0, s8_id}, 8, sh, op);
      chk("w8_rand_data", 64'(s8_od), exp);
      chk("w8_rand_valid", 64'(s8_ov), 64'(1));
    end
    s8_iv = 1'b0;
    #1 chk("w8_valid_follows", 64'(s8_ov), 64'(0));
    @(negedge clock);

    // 64-bit fully registered instance.
    send64("w64_sll_max", 64'd1, 63, OP_SLL);
    send64("w64_srl_zero", 64'd1, 1, OP_SRL);
    send64("w64_sra", 64'h8000_0000_0000_0000, 37, OP_SRA);
    for (int t = 0; t < 6; t++) begin
      send64("w64_rand", {$urandom, $urandom}, $urandom_range(0, 63),
             2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
